// File: rtl/mem_boot_loader.sv
// mem_boot_loader: boot sequencer between the host MEM AXI-stream and the
// core's unified instruction/data memory. Accepts {data, byte-address} beats
// and writes the valid ones to memory. The core is held in reset until the
// final beat has been committed and a settle delay has elapsed. Any beat with
// a bad address traps the block in ERROR, so a bad image can never start the
// core.
//
// Optional feature: define MEM_BOOT_LOADER_CHECKSUM_EN to make load_checksum
// accumulate the modulo-2^32 sum of all written words. When the macro is
// undefined, load_checksum is tied to zero.
module mem_boot_loader #(
  parameter int unsigned MEM_DEPTH     = 1048576,       // bytes, power of two, >= 4
  parameter logic [31:0] BASE_ADDR     = 32'h0100_0000, // byte address of word 0
  parameter int unsigned RELEASE_DELAY = 4,             // 0..255
  localparam int unsigned AW = ($clog2(MEM_DEPTH / 4) > 0) ? $clog2(MEM_DEPTH / 4) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_tvalid,
  output logic          MEM_tready,
  input  logic [63:0]   MEM_tdata,
  input  logic          MEM_tlast,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_error,
  output logic [31:0]   word_count,
  output logic [31:0]   load_checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_e;

  localparam logic [32:0] DEPTH_33   = 33'(MEM_DEPTH);
  localparam logic [7:0]  DELAY_INIT = 8'(RELEASE_DELAY);

  state_e         state_q;
  logic [7:0]     delay_q;
  logic           tready_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           core_rst_q;
  logic           done_q;
  logic           error_q;
  logic [31:0]    count_q;

  logic [32:0]    addr_off;
  logic           beat_fire;
  logic           beat_ok;
  logic [31:0]    count_d;

  // Decode the incoming beat: 33-bit offset so addresses below BASE_ADDR show
  // up as a set borrow bit instead of wrapping into range.
  always_comb begin
    addr_off  = {1'b0, MEM_tdata[31:0]} - {1'b0, BASE_ADDR};
    beat_fire = MEM_tvalid && tready_q && (state_q == S_LOAD);
    beat_ok   = !addr_off[32] && (addr_off < DEPTH_33) && (MEM_tdata[1:0] == 2'b00);
    count_d   = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
  end

  // Boot sequencer: state, handshake, write port and status all registered here.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      delay_q    <= '0;
      tready_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: the write strobe defaults low every cycle so it can only ever be
      // a one-cycle pulse per accepted valid beat.
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q  <= S_LOAD;
          tready_q <= 1'b1;
        end
        S_LOAD: begin
          if (beat_fire) begin
            if (beat_ok) begin
              we_q    <= 1'b1;
              addr_q  <= addr_off[AW+1:2];
              wdata_q <= MEM_tdata[63:32];
              count_q <= count_d;
            end else begin
              error_q <= 1'b1;
            end
            if (MEM_tlast) begin
              tready_q <= 1'b0;
              if (error_q || !beat_ok) begin
                state_q <= S_ERROR;
              end else begin
                state_q <= S_HOLD;
                delay_q <= DELAY_INIT;
              end
            end
          end
        end
        S_HOLD: begin
          if (delay_q != 8'd0) begin
            delay_q <= delay_q - 8'd1;
          end else begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        S_RUN: begin
          tready_q <= 1'b0;
        end
        S_ERROR: begin
          tready_q <= 1'b0;
        end
        default: begin
          state_q  <= S_ERROR;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_tready = tready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign word_count = count_q;

`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum of written words; only moves in LOAD, so it freezes from HOLD on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (beat_fire && beat_ok) begin
      checksum_q <= checksum_q + MEM_tdata[63:32];
    end
  end

  assign load_checksum = checksum_q;
`else
  assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// Self-checking bench for mem_boot_loader. A driver issues beats and pushes
// the expected memory writes into a scoreboard queue; a monitor pops and
// compares whenever the DUT strobes mem_we. Status outputs and release timing
// are compared against a behavioural model of the load rules.
module tb_mem_boot_loader;

  localparam int unsigned MEM_DEPTH = 1048576;
  localparam logic [31:0] BASE      = 32'h0100_0000;
  localparam int unsigned RD        = 4;
  localparam int unsigned AW        = $clog2(MEM_DEPTH / 4);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          MEM_tvalid = 1'b0;
  logic          MEM_tready;
  logic [63:0]   MEM_tdata = '0;
  logic          MEM_tlast = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_error;
  logic [31:0]   word_count;
  logic [31:0]   load_checksum;

  // Second instance with zero release delay, sharing clock and reset.
  logic          r0_tvalid = 1'b0;
  logic          r0_tready;
  logic [63:0]   r0_tdata = '0;
  logic          r0_tlast = 1'b0;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [31:0]   r0_wdata;
  logic          r0_core_rst;
  logic          r0_done;
  logic          r0_error;
  logic [31:0]   r0_count;
  logic [31:0]   r0_checksum;

  mem_boot_loader #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst(rst),
    .MEM_tvalid(MEM_tvalid), .MEM_tready(MEM_tready), .MEM_tdata(MEM_tdata),
    .MEM_tlast(MEM_tlast), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_error(load_error),
    .word_count(word_count), .load_checksum(load_checksum)
  );

  mem_boot_loader #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE), .RELEASE_DELAY(0)) dut_rd0 (
    .clk(clk), .rst(rst),
    .MEM_tvalid(r0_tvalid), .MEM_tready(r0_tready), .MEM_tdata(r0_tdata),
    .MEM_tlast(r0_tlast), .mem_we(r0_we), .mem_addr(r0_addr), .mem_wdata(r0_wdata),
    .core_rst(r0_core_rst), .load_done(r0_done), .load_error(r0_error),
    .word_count(r0_count), .load_checksum(r0_checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] m_count;
  bit          m_err;
  logic [31:0] m_sum;
  bit          m_loading;

  function automatic bit addr_valid(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off < longint'(MEM_DEPTH)) && (a % 4 == 0);
  endfunction

  function automatic logic [AW-1:0] addr_index(input logic [31:0] a);
    return AW'((a - BASE) / 4);
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      check("write_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        check("write_index", 64'(mem_addr), 64'(e.idx));
        check("write_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  // Asynchronous reset with immediate output checks, then release and wait for LOAD.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_tready", 64'(MEM_tready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    sb.delete();
    m_count = '0; m_err = 1'b0; m_sum = '0; m_loading = 1'b0;
    MEM_tvalid = 1'b0; MEM_tlast = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("load_tready", 64'(MEM_tready), 64'd1);
    m_loading = 1'b1;
  endtask

  // Issue one beat; the model decides what the accepted beat must produce.
  task automatic send(input logic [31:0] addr, input logic [31:0] data, input bit last);
    int budget = 0;
    MEM_tvalid = 1'b1;
    MEM_tdata  = {data, addr};
    MEM_tlast  = last;
    while (!MEM_tready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("tready_vs_model", 64'(MEM_tready), 64'(m_loading));
    if (MEM_tready) begin
      if (addr_valid(addr)) begin
        sb.push_back('{idx: addr_index(addr), data: data});
        if (m_count != 32'hFFFF_FFFF) m_count++;
        m_sum += data;
      end else begin
        m_err = 1'b1;
      end
      if (last) m_loading = 1'b0;
      @(negedge clk);
    end
    MEM_tvalid = 1'b0;
    MEM_tlast  = 1'b0;
  endtask

  // Called right after the tlast accept edge: checks release timing or trap.
  task automatic finish_image(input int hold_cycles);
    check("tready_after_last", 64'(MEM_tready), 64'd0);
    if (m_err) begin
      bit ok = 1'b1;
      repeat (hold_cycles) begin
        @(negedge clk);
        if (core_rst !== 1'b1 || load_done !== 1'b0 || MEM_tready !== 1'b0) ok = 1'b0;
      end
      check("error_trap_hold", 64'(ok), 64'd1);
    end else begin
      for (int i = 0; i < int'(RD); i++) begin
        @(negedge clk);
        check("core_rst_held", 64'(core_rst), 64'd1);
      end
      @(negedge clk);
      check("core_rst_released", 64'(core_rst), 64'd0);
      check("load_done", 64'(load_done), 64'd1);
    end
  endtask

  task automatic check_status();
    check("word_count", 64'(word_count), 64'(m_count));
    check("load_error", 64'(load_error), 64'(m_err));
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    check("checksum", 64'(load_checksum), 64'(m_sum));
`else
    check("checksum_tied", 64'(load_checksum), 64'd0);
`endif
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0: return BASE - 32'(4 * $urandom_range(1, 16));
      1: return BASE + 32'(MEM_DEPTH) + 32'(4 * $urandom_range(0, 16));
      2: return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      3: return BASE + 32'(MEM_DEPTH) - 32'(4 * $urandom_range(1, 4));
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_count = '0; m_err = 1'b0; m_sum = '0; m_loading = 1'b0;
    // Reset values, with tvalid already high during reset and IDLE.
    MEM_tvalid = 1'b1;
    MEM_tdata  = {32'hAAAA_5555, BASE + 32'h10};
    repeat (3) @(negedge clk);
    check("reset_tready", 64'(MEM_tready), 64'd0);
    check("reset_mem_we", 64'(mem_we), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    check("reset_core_rst", 64'(core_rst), 64'd1);
    check("reset_load_done", 64'(load_done), 64'd0);
    check("reset_load_error", 64'(load_error), 64'd0);
    check("reset_word_count", 64'(word_count), 64'd0);
    check("reset_checksum", 64'(load_checksum), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_accept_count", 64'(word_count), 64'd0);
    check("idle_tready", 64'(MEM_tready), 64'd1);
    MEM_tvalid = 1'b0;

    // Zero release delay: single tlast beat on the second instance.
    r0_tvalid = 1'b1; r0_tlast = 1'b1; r0_tdata = {32'hDEAD_BEEF, BASE + 32'h8};
    check("rd0_tready", 64'(r0_tready), 64'd1);
    @(negedge clk);
    r0_tvalid = 1'b0; r0_tlast = 1'b0;
    check("rd0_we", 64'(r0_we), 64'd1);
    check("rd0_addr", 64'(r0_addr), 64'd2);
    check("rd0_wdata", 64'(r0_wdata), 64'hDEAD_BEEF);
    check("rd0_core_rst_held", 64'(r0_core_rst), 64'd1);
    @(negedge clk);
    check("rd0_core_rst_released", 64'(r0_core_rst), 64'd0);
    check("rd0_done", 64'(r0_done), 64'd1);
    check("rd0_we_low", 64'(r0_we), 64'd0);
    check("rd0_count", 64'(r0_count), 64'd1);

    // Directed three-beat image.
    do_reset();
    send(BASE + 32'h0, 32'h11, 1'b0);
    send(BASE + 32'h4, 32'h22, 1'b0);
    send(BASE + 32'h8, 32'h33, 1'b1);
    finish_image(0);
    check_status();
    // Beats offered after RUN must be ignored.
    MEM_tvalid = 1'b1;
    MEM_tdata  = {32'h5A5A_5A5A, BASE + 32'h10};
    repeat (10) @(negedge clk);
    MEM_tvalid = 1'b0;
    check("run_tready", 64'(MEM_tready), 64'd0);
    check_status();

    // Below-base and misaligned beats trap the load.
    do_reset();
    send(32'h00FF_FFFC, 32'h1, 1'b0);
    send(BASE + 32'h2, 32'h2, 1'b0);
    send(BASE, 32'h3, 1'b1);
    finish_image(1000);
    check_status();

    // Top-of-memory boundary.
    do_reset();
    send(BASE + 32'(MEM_DEPTH) - 32'd4, 32'hCAFE_0001, 1'b0);
    check("boundary_no_error", 64'(load_error), 64'd0);
    send(BASE + 32'(MEM_DEPTH), 32'hCAFE_0002, 1'b0);
    check("boundary_error", 64'(load_error), 64'd1);
    send(BASE, 32'hCAFE_0003, 1'b1);
    finish_image(20);
    check_status();

    // Reset two beats into a five-beat load, then a full reload.
    do_reset();
    send(BASE + 32'h0, 32'h100, 1'b0);
    send(BASE + 32'h4, 32'h200, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) send(BASE + 32'(4 * i), 32'(i + 1) * 32'h0101_0101, i == 4);
    finish_image(0);
    check_status();

    // Randomized images.
    for (int img = 0; img < 8; img++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 30);
      for (int b = 0; b < n; b++) send(rand_addr(), $urandom(), b == n - 1);
      finish_image(30);
      check_status();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
